// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with synchronous multi-port reads, sequential clear and streamed dump.
module regfile_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   read_address,
    output logic [NRD*XLEN-1:0] data_out,
    input  logic                WriteEnable,
    input  logic [AW-1:0]       write_address,
    input  logic [XLEN-1:0]     write_data_in,
    input  logic                clear_start,
    input  logic                dump_start,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_index,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_done,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;
    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NRD*XLEN-1:0] data_out_q, data_out_d;
    logic                dump_done_q, dump_done_d;
    logic                we;
    logic [AW-1:0]       ra;

    // Writes to x0 and writes during CLEAR never commit, so they must not bypass either.
    assign we = WriteEnable && state_q != CLEAR && write_address != '0;

    always_comb begin
        regs_d      = regs_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        dump_done_d = 1'b0;
        if (we) regs_d[write_address] = write_data_in;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                end else if (dump_start) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = '0;
                state_d       = &cnt_q ? IDLE : CLEAR;
                cnt_d         = cnt_q + AW'(1);
            end
            DUMP: begin
                if (dump_ready) begin
                    state_d     = &cnt_q ? IDLE : DUMP;
                    dump_done_d = &cnt_q;
                    cnt_d       = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        regs_d[0] = '0;
    end

    always_comb begin
        data_out_d = '0;
        ra         = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = read_address[p*AW +: AW];
            data_out_d[p*XLEN +: XLEN] = (we && write_address == ra) ? write_data_in : regs_q[ra];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            regs_q      <= '{default: '0};
            data_out_q  <= '0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            data_out_q  <= data_out_d;
            dump_done_q <= dump_done_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign dump_valid = state_q == DUMP;
    assign dump_index = dump_valid ? cnt_q : '0;
    assign dump_data  = dump_valid ? regs_q[cnt_q] : '0;
    assign data_out   = data_out_q;
    assign dump_done  = dump_done_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param covering reads, bypass, clear, dump and reset.
module tb_regfile_param;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

    logic                clock = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   read_address;
    logic [NRD*XLEN-1:0] data_out;
    logic                WriteEnable;
    logic [AW-1:0]       write_address;
    logic [XLEN-1:0]     write_data_in;
    logic                clear_start, dump_start, dump_valid, dump_ready, dump_done, busy;
    logic [AW-1:0]       dump_index;
    logic [XLEN-1:0]     dump_data;

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clock(clock), .reset(reset), .read_address(read_address), .data_out(data_out),
        .WriteEnable(WriteEnable), .write_address(write_address), .write_data_in(write_data_in),
        .clear_start(clear_start), .dump_start(dump_start), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data),
        .dump_done(dump_done), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {int due; int port; logic [XLEN-1:0] exp; int tag;} rd_t;
    typedef struct {logic [AW-1:0] idx; logic [XLEN-1:0] data;} beat_t;
    rd_t   rq[$];
    beat_t dq[$];
    int    cyc = 0, checks = 0, errors = 0, done_cnt = 0, tag = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: read results are due one edge after issue; dump beats are checked every valid cycle until accepted.
    always @(negedge clock) begin
        rd_t e;
        logic [XLEN-1:0] got;
        while (rq.size() != 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            got = data_out[e.port*XLEN +: XLEN];
            checks++;
            if (e.due != cyc || got !== e.exp) begin
                errors++;
                $display("FAIL read%0d port%0d: got %h expected %h", e.tag, e.port, got, e.exp);
            end
        end
        if (dump_valid) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL dump_unexpected: got beat idx %0d data %h expected no beat", dump_index, dump_data);
            end else begin
                if (dump_index !== dq[0].idx || dump_data !== dq[0].data) begin
                    errors++;
                    $display("FAIL dump_beat: got idx %0d data %h expected idx %0d data %h",
                             dump_index, dump_data, dq[0].idx, dq[0].data);
                end
                if (dump_ready) void'(dq.pop_front());
            end
        end
        if (dump_done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d);
        WriteEnable = 1'b1;
        write_address = AW'(a);
        write_data_in = d;
        step();
        WriteEnable = 1'b0;
    endtask

    task automatic rd(input int p, input int a, input logic [XLEN-1:0] exp);
        read_address[p*AW +: AW] = AW'(a);
        rq.push_back('{cyc + 1, p, exp, tag});
        tag++;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v;
        beat_t b;
        reset = 1'b1; read_address = '0; WriteEnable = 1'b0; write_address = '0; write_data_in = '0;
        clear_start = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_valid", dump_valid, 0);
        chk("reset_done", dump_done, 0);
        chk("reset_data_out", data_out, 0);
        step(); step();
        reset = 1'b0;

        wr(5, 32'hDEADBEEF);
        rd(0, 5, 32'hDEADBEEF);
        wr(0, 32'h1234);
        rd(0, 0, 32'h0);

        // Same-edge write and read: bypass on x7, none on x0.
        read_address[AW +: AW] = 5'd7;
        WriteEnable = 1'b1; write_address = 5'd7; write_data_in = 32'hA5A5A5A5;
        rq.push_back('{cyc + 1, 1, 32'hA5A5A5A5, tag}); tag++;
        step();
        read_address[0 +: AW] = 5'd0;
        write_address = 5'd0; write_data_in = 32'h55;
        rq.push_back('{cyc + 1, 0, 32'h0, tag}); tag++;
        step();
        WriteEnable = 1'b0;
        rd(0, 7, 32'hA5A5A5A5);

        for (int r = 1; r < NREGS; r++) wr(r, XLEN'(r * 3));
        rd(1, 31, 32'd93);
        rd(0, 1, 32'd3);

        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            WriteEnable = (n == 20);
            write_address = 5'd9; write_data_in = 32'hFFFF;
            if (n == 15) chk("clear_no_valid", dump_valid, 0);
            step();
        end
        WriteEnable = 1'b0;
        chk("clear_busy_cycles", n, 31);
        for (int r = 0; r < NREGS; r++) rd(0, r, 32'h0);

        for (int r = 1; r < NREGS; r++) wr(r, XLEN'(r));
        for (int i = 0; i < NREGS; i++) begin
            b.idx = AW'(i);
            b.data = (i == 20) ? 32'h777 : XLEN'(i);
            dq.push_back(b);
        end
        dump_start = 1'b1;
        WriteEnable = 1'b1; write_address = 5'd20; write_data_in = 32'h777;
        step();
        dump_start = 1'b0; WriteEnable = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            dump_ready = n[0];
            n++;
            step();
        end
        dump_ready = 1'b0;
        chk("dump_done_seen", done_cnt, 1);
        step(); step();
        chk("dump_done_pulse", done_cnt, 1);
        chk("dump_beats_left", dq.size(), 0);
        chk("dump_idle_busy", busy, 0);

        clear_start = 1'b1; dump_start = 1'b1;
        step();
        clear_start = 1'b0; dump_start = 1'b0;
        chk("both_busy", busy, 1);
        n = 0; v = 0;
        while (busy && n < 100) begin
            n++;
            if (dump_valid) v++;
            step();
        end
        chk("both_no_valid", v, 0);
        chk("both_clear_len", n, 31);

        wr(3, 32'd33);
        wr(10, 32'd100);
        for (int i = 0; i < 10; i++) begin
            b.idx = AW'(i);
            b.data = (i == 3) ? 32'd33 : 32'd0;
            dq.push_back(b);
        end
        dump_ready = 1'b1; dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        n = 0;
        while (dump_index != 5'd10 && n < 100) begin
            n++;
            step();
        end
        chk("reach_beat10", dump_index, 10);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", dump_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_index", dump_index, 0);
        chk("rst_mid_data", dump_data, 0);
        chk("rst_mid_data_out", data_out, 0);
        step();
        reset = 1'b0; dump_ready = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_valid", dump_valid, 0);
        rd(0, 3, 32'h0);
        rd(1, 10, 32'h0);
        step(); step();
        chk("read_queue_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
